mmp_mixer_tdm: RTL and testbench

//  Parametrised, time-multiplexed N-channel sound mixer; successor to the fixed 4-source combinational mix.

---
 rtl/mmp_mixer_tdm.sv | 216 +++++++++++++++++++++
 tb/tb_mmp_mixer_tdm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmp_mixer_tdm.sv
// mmp_mixer_tdm: time-multiplexed N-channel signed mixer.
// Captures one frame of samples, mutes and gains on a strobe, then accumulates one channel per
// clock through a single multiplier and saturates the sum to OUT_W bits.
// The result is presented on o_MIX together with a one-cycle o_MIX_STB pulse.
module mmp_mixer_tdm #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned IN_W      = 16,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned GAIN_W    = 8,
   parameter int unsigned GAIN_FRAC = 5,
   localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_SMPL_STB,
   input  logic [NUM_CH*IN_W-1:0]   i_SAMPLES,
   input  logic [NUM_CH-1:0]        i_MUTE,
   input  logic                     i_GAIN_WE,
   input  logic [CH_W-1:0]          i_GAIN_CH,
   input  logic [GAIN_W-1:0]        i_GAIN_DT,
   input  logic                     i_OVR_CLR,
   output logic [OUT_W-1:0]         o_MIX,
   output logic                     o_MIX_STB,
   output logic                     o_CLIP,
   output logic                     o_BUSY,
   output logic                     o_OVERRUN
);

   localparam int unsigned PROD_W = IN_W + GAIN_W;
   // One guard bit beyond log2(NUM_CH) so the running sum can never wrap.
   localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_CH) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_SAT  = 2'd2;

   localparam logic [CH_W-1:0]   LAST_IDX   = CH_W'(NUM_CH - 1);
   localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << GAIN_FRAC);

   // FSM and datapath state
   logic [1:0]               state_q, state_d;
   logic [CH_W-1:0]          idx_q, idx_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;

   // Live gain registers and the per-frame snapshot used by the MAC
   logic [GAIN_W-1:0]        gain_q  [NUM_CH];
   logic [GAIN_W-1:0]        gain_d  [NUM_CH];
   logic [GAIN_W-1:0]        gsnap_q [NUM_CH];
   logic [GAIN_W-1:0]        gsnap_d [NUM_CH];

   // Captured frame
   logic [IN_W-1:0]          smp_q [NUM_CH];
   logic [IN_W-1:0]          smp_d [NUM_CH];
   logic [NUM_CH-1:0]        mute_q, mute_d;

   // Output registers
   logic [OUT_W-1:0]         mix_q, mix_d;
   logic                     mix_stb_q, mix_stb_d;
   logic                     clip_q, clip_d;
   logic                     ovr_q, ovr_d;

   // MAC term and saturation results
   logic [IN_W-1:0]          cur_smp;
   logic [GAIN_W-1:0]        cur_gain;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] prod_shr;
   logic signed [ACC_W-1:0]  term;
   logic [OUT_W-1:0]         sat_val;
   logic                     sat_clip;

   // Gain register file update; indices outside 0..NUM_CH-1 never match and are dropped.
   always_comb begin
      gain_d = gain_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (i_GAIN_WE && (i_GAIN_CH == CH_W'(k))) begin
            gain_d[k] = i_GAIN_DT;
         end
      end
   end

   // Scaled, muted term for the channel selected by idx_q (floor rounding via arithmetic shift).
   always_comb begin
      cur_smp  = smp_q[idx_q];
      cur_gain = gsnap_q[idx_q];
      prod     = $signed({{GAIN_W{cur_smp[IN_W-1]}}, cur_smp}) *
                 $signed({{IN_W{cur_gain[GAIN_W-1]}}, cur_gain});
      prod_shr = prod >>> GAIN_FRAC;
      if (mute_q[idx_q]) begin
         term = '0;
      end else begin
         term = $signed({{(ACC_W - PROD_W){prod_shr[PROD_W-1]}}, prod_shr});
      end
   end

   generate
      if (OUT_W >= ACC_W) begin : g_extend
         // Output wide enough for any sum: sign-extend, never clip.
         always_comb begin
            sat_val  = OUT_W'(acc_q);
            sat_clip = 1'b0;
         end
      end else begin : g_clamp
         logic [ACC_W-OUT_W:0] acc_top;
         logic                 in_range;

         // Sum fits iff every bit from the output sign bit upward agrees.
         always_comb begin
            acc_top  = acc_q[ACC_W-1:OUT_W-1];
            in_range = (acc_top == '0) || (acc_top == '1);
            sat_clip = ~in_range;
            if (in_range) begin
               sat_val = acc_q[OUT_W-1:0];
            end else if (acc_q[ACC_W-1]) begin
               sat_val = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
               sat_val = {1'b0, {(OUT_W-1){1'b1}}};
            end
         end
      end
   endgenerate

   // Frame FSM: capture in IDLE, one MAC per cycle, then saturate and publish.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      smp_d     = smp_q;
      mute_d    = mute_q;
      gsnap_d   = gsnap_q;
      mix_d     = mix_q;
      mix_stb_d = 1'b0;
      clip_d    = 1'b0;
      ovr_d     = ovr_q;

      // Clear first so a same-edge overrun set takes priority below.
      if (i_OVR_CLR) begin
         ovr_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (i_SMPL_STB) begin
               for (int k = 0; k < NUM_CH; k++) begin
                  smp_d[k] = i_SAMPLES[k*IN_W +: IN_W];
               end
               mute_d  = i_MUTE;
               gsnap_d = gain_q;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            if (i_SMPL_STB) begin
               ovr_d = 1'b1;
            end
            acc_d = acc_q + term;
            if (idx_q == LAST_IDX) begin
               state_d = ST_SAT;
            end else begin
               idx_d = idx_q + CH_W'(1);
            end
         end
         ST_SAT: begin
            if (i_SMPL_STB) begin
               ovr_d = 1'b1;
            end
            mix_d     = sat_val;
            clip_d    = sat_clip;
            mix_stb_d = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset also restores unity gains.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         mute_q    <= '0;
         mix_q     <= '0;
         mix_stb_q <= 1'b0;
         clip_q    <= 1'b0;
         ovr_q     <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            gain_q[k]  <= GAIN_UNITY;
            gsnap_q[k] <= GAIN_UNITY;
            smp_q[k]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         mute_q    <= mute_d;
         mix_q     <= mix_d;
         mix_stb_q <= mix_stb_d;
         clip_q    <= clip_d;
         ovr_q     <= ovr_d;
         gain_q    <= gain_d;
         gsnap_q   <= gsnap_d;
         smp_q     <= smp_d;
      end
   end

   assign o_MIX     = mix_q;
   assign o_MIX_STB = mix_stb_q;
   assign o_CLIP    = clip_q;
   assign o_BUSY    = (state_q != ST_IDLE);
   assign o_OVERRUN = ovr_q;

endmodule

// File: tb/tb_mmp_mixer_tdm.sv
// tb_mmp_mixer_tdm: scoreboard bench for mmp_mixer_tdm at default parameters.
module tb_mmp_mixer_tdm;

   localparam int NUM_CH    = 4;
   localparam int IN_W      = 16;
   localparam int OUT_W     = 16;
   localparam int GAIN_W    = 8;
   localparam int GAIN_FRAC = 5;
   localparam int CH_W      = 2;

   typedef struct {
      int mix;
      int clip;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   smpl_stb;
   logic [NUM_CH*IN_W-1:0] samples;
   logic [NUM_CH-1:0]      mute;
   logic                   gain_we;
   logic [CH_W-1:0]        gain_ch;
   logic [GAIN_W-1:0]      gain_dt;
   logic                   ovr_clr;
   logic [OUT_W-1:0]       mix;
   logic                   mix_stb;
   logic                   clip;
   logic                   busy;
   logic                   overrun;

   exp_t exp_q[$];
   exp_t mon_e;
   int   gm[NUM_CH];
   int   n_chk = 0;
   int   n_err = 0;
   int   s[NUM_CH];

   always #5 clk = ~clk;

   mmp_mixer_tdm #(
      .NUM_CH    (NUM_CH),
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
   ) u_dut (
      .i_CLK      (clk),
      .i_RST      (rst),
      .i_SMPL_STB (smpl_stb),
      .i_SAMPLES  (samples),
      .i_MUTE     (mute),
      .i_GAIN_WE  (gain_we),
      .i_GAIN_CH  (gain_ch),
      .i_GAIN_DT  (gain_dt),
      .i_OVR_CLR  (ovr_clr),
      .o_MIX      (mix),
      .o_MIX_STB  (mix_stb),
      .o_CLIP     (clip),
      .o_BUSY     (busy),
      .o_OVERRUN  (overrun)
   );

   task automatic check_val(input string tag, input int got, input int want);
      n_chk++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference mix from the bench's own gain model.
   function automatic exp_t model_mix(input int sv[NUM_CH], input logic [NUM_CH-1:0] m);
      longint acc;
      exp_t   e;
      acc = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!m[k]) acc += (longint'(sv[k]) * longint'(gm[k])) >>> GAIN_FRAC;
      end
      if (acc > 32767) begin
         e.mix = 32767;  e.clip = 1;
      end else if (acc < -32768) begin
         e.mix = -32768; e.clip = 1;
      end else begin
         e.mix = int'(acc); e.clip = 0;
      end
      return e;
   endfunction

   // One-cycle strobe; the expectation is queued only when the DUT should accept it.
   task automatic drive_frame(input int sv[NUM_CH], input logic [NUM_CH-1:0] m, input bit accept);
      for (int k = 0; k < NUM_CH; k++) samples[k*IN_W +: IN_W] = IN_W'(sv[k]);
      mute     = m;
      smpl_stb = 1'b1;
      if (accept) exp_q.push_back(model_mix(sv, m));
      tick();
      smpl_stb = 1'b0;
   endtask

   task automatic set_gain(input int ch, input int val);
      gain_we = 1'b1;
      gain_ch = CH_W'(ch);
      gain_dt = GAIN_W'(val);
      tick();
      gain_we = 1'b0;
      if (ch < NUM_CH) gm[ch] = val;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 50) begin
         tick();
         n++;
      end
      check_val("done_timeout", int'(n < 50), 1);
   endtask

   // Result monitor: pops the scoreboard on every output strobe.
   always @(negedge clk) begin
      if (mix_stb) begin
         check_val("stb_expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_val("mix", int'($signed(mix)), mon_e.mix);
            check_val("clip", int'(clip), mon_e.clip);
         end
      end else if (clip) begin
         check_val("clip_idle", int'(clip), 0);
      end
   end

   initial begin
      rst = 1'b1; smpl_stb = 1'b0; samples = '0; mute = '0;
      gain_we = 1'b0; gain_ch = '0; gain_dt = '0; ovr_clr = 1'b0;
      for (int k = 0; k < NUM_CH; k++) gm[k] = 32;
      tick();
      tick();
      rst = 1'b0;
      check_val("rst_mix", int'($signed(mix)), 0);
      check_val("rst_stb", int'(mix_stb), 0);
      check_val("rst_clip", int'(clip), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_ovr", int'(overrun), 0);

      // Unity mix and exact latency
      s = '{1000, 2000, -500, 0};
      drive_frame(s, 4'b0000, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check_val("t1_stb_timing", int'(mix_stb), int'(i == 5));
         check_val("t1_busy", int'(busy), int'(i < 5));
      end
      wait_done();

      // Saturation both ways
      s = '{30000, 30000, 30000, 30000};
      drive_frame(s, 4'b0000, 1'b1);
      wait_done();
      s = '{-30000, -30000, -30000, -30000};
      drive_frame(s, 4'b0000, 1'b1);
      wait_done();

      // Mute
      s = '{100, 200, 300, 400};
      drive_frame(s, 4'b0010, 1'b1);
      wait_done();

      // Overrun: strobe at k+3 ignored; clear on same edge loses to set
      s = '{111, 222, 333, 444};
      drive_frame(s, 4'b0000, 1'b1);
      tick();
      tick();
      ovr_clr = 1'b1;
      s = '{9999, 9999, 9999, 9999};
      drive_frame(s, 4'b0000, 1'b0);
      ovr_clr = 1'b0;
      check_val("t5_ovr_set", int'(overrun), 1);
      tick();
      tick();
      // Strobe at k+6 accepted; clear lands on the same edge
      ovr_clr = 1'b1;
      s = '{-7, 8, 16, 32};
      drive_frame(s, 4'b0000, 1'b1);
      ovr_clr = 1'b0;
      check_val("t5_ovr_clr", int'(overrun), 0);
      check_val("t5_busy", int'(busy), 1);
      wait_done();

      // Gain and floor rounding
      set_gain(1, 0);
      set_gain(2, 0);
      set_gain(3, 0);
      set_gain(0, 16);
      s = '{-3, 500, 500, 500};
      drive_frame(s, 4'b0000, 1'b1);
      wait_done();
      set_gain(1, 32);
      s = '{0, 100, 0, 0};
      drive_frame(s, 4'b0000, 1'b1);
      set_gain(1, 64);
      wait_done();
      drive_frame(s, 4'b0000, 1'b1);
      wait_done();
      // Write on the capture edge misses this frame's snapshot
      gain_we = 1'b1; gain_ch = 2'd1; gain_dt = 8'd32;
      drive_frame(s, 4'b0000, 1'b1);
      gain_we = 1'b0;
      gm[1] = 32;
      wait_done();
      drive_frame(s, 4'b0000, 1'b1);
      wait_done();

      // Reset mid-frame aborts and restores unity gains
      set_gain(0, 64);
      s = '{1000, 0, 0, 0};
      drive_frame(s, 4'b0000, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < NUM_CH; k++) gm[k] = 32;
      check_val("t6_mix", int'($signed(mix)), 0);
      check_val("t6_busy", int'(busy), 0);
      for (int i = 0; i < 8; i++) tick();
      s = '{1000, 2000, 3000, -4000};
      drive_frame(s, 4'b0000, 1'b1);
      wait_done();

      tick();
      check_val("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
